// File: rtl/mont_mul_pipe.sv
// Three-stage pipelined Montgomery multiplier (REDC) with valid/ready flow control.
// Modes: multiply, convert into the Montgomery domain, convert out of it.
module mont_mul_pipe #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] MOD    = WIDTH'(998244353),
  parameter logic [WIDTH-1:0] NPRIME = WIDTH'(998244351),
  parameter logic [WIDTH-1:0] R2MOD  = WIDTH'(932051910),
  parameter int unsigned      TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             in_err;
  logic [W2-1:0]    t_next;

  logic             s1_valid;
  logic             s1_err;
  logic [W2-1:0]    s1_t;
  logic [TAG_W-1:0] s1_tag;
  logic [WIDTH-1:0] m_next;

  logic             s2_valid;
  logic             s2_err;
  logic [W2-1:0]    s2_t;
  logic [WIDTH-1:0] s2_m;
  logic [TAG_W-1:0] s2_tag;

  logic [W2-1:0]    mm;
  logic [W2:0]      sum;
  logic [WIDTH:0]   u;
  logic [WIDTH:0]   u_red;
  logic             sum_lo_unused;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    case (in_op)
      2'd1:    b_eff = R2MOD;
      2'd2:    b_eff = WIDTH'(1);
      default: b_eff = in_b;
    endcase
  end

  assign in_err = (in_a >= MOD) | (b_eff >= MOD) | (in_op == 2'd3);
  assign t_next = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, b_eff};

  // Truncating to WIDTH bits gives the mod-R reduction for free.
  assign m_next = s1_t[WIDTH-1:0] * NPRIME;

  // Low half of the sum is zero by construction of m; only the carry matters.
  assign mm            = {{WIDTH{1'b0}}, s2_m} * {{WIDTH{1'b0}}, MOD};
  assign sum           = {1'b0, s2_t} + {1'b0, mm};
  assign u             = sum[W2:WIDTH];
  assign u_red         = (u >= {1'b0, MOD}) ? (u - {1'b0, MOD}) : u;
  assign sum_lo_unused = ^{sum[WIDTH-1:0], u_red[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_t      <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_err    <= 1'b0;
      s2_t      <= '0;
      s2_m      <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_err    <= in_err;
      s1_t      <= t_next;
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_err    <= s1_err;
      s2_t      <= s1_t;
      s2_m      <= m_next;
      s2_tag    <= s1_tag;
      out_valid <= s2_valid;
      out_data  <= u_red[WIDTH-1:0];
      out_tag   <= s2_tag;
      out_err   <= s2_err;
    end
  end

endmodule

// File: tb/tb_mont_mul_pipe.sv
// Self-checking bench for mont_mul_pipe: directed mode checks, a randomized
// backpressured stream against a modular-arithmetic reference, and reset flush.
module tb_mont_mul_pipe;

  localparam int unsigned       W      = 32;
  localparam int unsigned       TAG_W  = 4;
  localparam longint unsigned   MOD    = 64'd998244353;
  localparam longint unsigned   NPRIME = 64'd998244351;
  localparam longint unsigned   R2MOD  = 64'd932051910;
  localparam longint unsigned   RMOD   = 64'd301989884;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  mont_mul_pipe #(
    .WIDTH (W),
    .MOD   (W'(MOD)),
    .NPRIME(W'(NPRIME)),
    .R2MOD (W'(R2MOD)),
    .TAG_W (TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  longint unsigned rinv;

  typedef struct {
    longint unsigned data;
    longint unsigned tag;
  } exp_t;

  task automatic check(input string name, input longint unsigned obs, input longint unsigned exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
  endtask

  function automatic longint unsigned modmul(input longint unsigned a, input longint unsigned b);
    return ((a % MOD) * (b % MOD)) % MOD;
  endfunction

  function automatic longint unsigned modpow(input longint unsigned base, input longint unsigned e);
    longint unsigned r = 1;
    longint unsigned b = base % MOD;
    longint unsigned k = e;
    while (k != 0) begin
      if (k[0]) r = modmul(r, b);
      b = modmul(b, b);
      k = k >> 1;
    end
    return r;
  endfunction

  // Reference: a * b_eff * R^-1 mod MOD (valid for in-range operands).
  function automatic longint unsigned ref_data(input int op, input longint unsigned a, input longint unsigned b);
    longint unsigned bb;
    bb = (op == 1) ? R2MOD : (op == 2) ? 64'd1 : b;
    return modmul(modmul(a, bb), rinv);
  endfunction

  task automatic single(input int op, input longint unsigned a, input longint unsigned b,
                        input int tag, input string name,
                        output longint unsigned d, output longint unsigned t,
                        output longint unsigned e);
    int edges;
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = 2'(op);
    in_a      = W'(a);
    in_b      = W'(b);
    in_tag    = TAG_W'(tag);
    out_ready = 1'b1;
    #1 check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 8) begin
      @(negedge clk);
      edges++;
    end
    check({name, "_latency"}, edges, 3);
    d = out_data;
    t = out_tag;
    e = out_err;
  endtask

  initial begin
    longint unsigned d, t, e, x;
    exp_t q[$];
    exp_t front;
    longint unsigned sa [16];
    longint unsigned sb [16];
    int sent, rcvd, cyc, extra;
    logic acc, del, held;
    longint unsigned held_d, held_t;

    rinv      = modpow(64'd1 << 32, MOD - 2);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    single(2, RMOD, 0, 0, "from_mont_r", d, t, e);
    check("from_mont_r_data", d, 1);
    check("from_mont_r_err", e, 0);

    single(1, 1, 0, 5, "to_mont_1", d, t, e);
    check("to_mont_1_data", d, RMOD);
    check("to_mont_1_tag", t, 5);

    single(1, 5, 0, 2, "to_mont_5", x, t, e);
    check("to_mont_5_data", x, ref_data(1, 5, 0));
    single(2, x, 0, 3, "round_trip", d, t, e);
    check("round_trip_data", d, 5);

    single(0, RMOD, RMOD, 7, "mul_one", d, t, e);
    check("mul_one_data", d, RMOD);
    single(0, 0, 12345, 8, "mul_zero", d, t, e);
    check("mul_zero_data", d, 0);

    single(0, MOD, 2, 9, "err_a", d, t, e);
    check("err_a_err", e, 1);
    single(3, 7, 9, 10, "err_op3", d, t, e);
    check("err_op3_err", e, 1);
    check("err_op3_data", d, ref_data(0, 7, 9));
    single(0, 123456789, 987654321, 11, "after_err", d, t, e);
    check("after_err_err", e, 0);
    check("after_err_data", d, ref_data(0, 123456789, 987654321));

    // Randomized back-to-back stream with pseudo-random backpressure.
    for (int i = 0; i < 16; i++) begin
      sa[i] = longint'($urandom_range(32'(MOD - 1), 0));
      sb[i] = longint'($urandom_range(32'(MOD - 1), 0));
    end
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    held = 1'b0;
    held_d = 0;
    held_t = 0;
    while (rcvd < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(1, 0));
      if (sent < 16) begin
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_a     = W'(sa[sent]);
        in_b     = W'(sb[sent]);
        in_tag   = TAG_W'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("stream_in_ready", in_ready, !(out_valid && !out_ready));
      if (held && out_valid) begin
        check("stall_hold_data", out_data, held_d);
        check("stall_hold_tag", out_tag, held_t);
      end
      acc = in_valid & in_ready;
      del = out_valid & out_ready;
      held = out_valid & ~out_ready;
      held_d = out_data;
      held_t = out_tag;
      if (del) begin
        if (q.size() == 0) begin
          check("stream_unexpected_output", 1, 0);
        end else begin
          front = q.pop_front();
          check("stream_data", out_data, front.data);
          check("stream_tag", out_tag, front.tag);
          check("stream_err", out_err, 0);
        end
        rcvd++;
      end
      if (acc) begin
        q.push_back('{data: ref_data(0, sa[sent], sb[sent]), tag: longint'(sent)});
      end
      @(posedge clk);
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_received", rcvd, 16);
    check("stream_queue_empty", q.size(), 0);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("stream_no_extra", extra, 0);

    // Fill all three stages, then reset with everything in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'd0;
      in_a     = W'(i + 2);
      in_b     = W'(i + 3);
      in_tag   = TAG_W'(i + 12);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("full_out_valid", out_valid, 1);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_tag", out_tag, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("midrst_no_stale", extra, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
